// File: rtl/shift_register_unit.sv
// Parametrised register: sync clear, parallel load, multi-cycle serial shift by run-time amount.
// Latency: load 1 cycle; shift of n>0 takes n cycles busy, done pulses the cycle after (n+1 total).
// Backpressure: load/start ignored while busy; SHIFT_REGISTER_UNIT_ARITH_EN makes right shifts arithmetic.
module shift_register_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] amount,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               sout_q, sout_d;
  logic               done_q, done_d;
  logic               fill;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef SHIFT_REGISTER_UNIT_ARITH_EN
  assign fill = data_q[WIDTH-1];
`else
  assign fill = serial_in;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      data_q  <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    data_d  = data_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr) begin
          data_d = '0;
          sout_d = 1'b0;
        end else if (load) begin
          data_d = data_in;
        end else if (start) begin
          // A zero-length shift completes immediately without entering SHIFT.
          if (amount == '0) begin
            done_d = 1'b1;
          end else begin
            cnt_d   = amount;
            dir_d   = dir;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (clr) begin
          data_d  = '0;
          sout_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          if (dir_q) begin
            data_d = {fill, data_q[WIDTH-1:1]};
            sout_d = data_q[0];
          end else begin
            data_d = {data_q[WIDTH-2:0], serial_in};
            sout_d = data_q[WIDTH-1];
          end
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_out   = data_q;
  assign serial_out = sout_q;
  assign busy       = (state_q == SHIFT);
  assign done       = done_q;

endmodule

// File: tb/tb_shift_register_unit.sv
// Self-checking bench for shift_register_unit: directed scenarios plus randomized shifts vs a bit-stream model.
module tb_shift_register_unit;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clr = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             start = 1'b0;
  logic             dir = 1'b0;
  logic [CNT_W-1:0] amount = '0;
  logic             serial_in = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             serial_out;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  shift_register_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .data_in(data_in),
    .start(start), .dir(dir), .amount(amount), .serial_in(serial_in),
    .data_out(data_out), .serial_out(serial_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    load = 1'b1;
    data_in = v;
    tick();
    load = 1'b0;
  endtask

  task automatic do_start(input logic d, input int n, input logic s);
    dir = d;
    amount = CNT_W'(n);
    serial_in = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({data_out, serial_out, busy, done} !== {8'h00, 3'b000}) begin
      errors++;
      $display("FAIL reset_init: got data=%h sout=%b busy=%b done=%b, want 00 0 0 0", data_out, serial_out, busy, done);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    do_load(8'hAB);
    do_start(1'b0, 9, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_busy: got busy=%b, want 1", busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({data_out, serial_out, busy, done} !== {8'h00, 3'b000}) begin
      errors++;
      $display("FAIL reset_async: got data=%h sout=%b busy=%b done=%b, want 00 0 0 0", data_out, serial_out, busy, done);
    end
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_done: cycle %0d got busy=%b done=%b, want 0 0", i, busy, done);
      end
    end
  endtask

  task automatic test_left();
    logic [WIDTH-1:0] exp_seq [3];
    exp_seq[0] = 8'h4B; exp_seq[1] = 8'h97; exp_seq[2] = 8'h2F;
    do_load(8'hA5);
    checks++;
    if (data_out !== 8'hA5) begin
      errors++;
      $display("FAIL left_load: got %h, want a5", data_out);
    end
    do_start(1'b0, 3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL left_busy: step %0d got busy=%b done=%b, want 1 0", i, busy, done);
      end
      tick();
      checks++;
      if (data_out !== exp_seq[i]) begin
        errors++;
        $display("FAIL left_data: step %0d got %h, want %h", i, data_out, exp_seq[i]);
      end
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || serial_out !== 1'b1) begin
      errors++;
      $display("FAIL left_done: got busy=%b done=%b sout=%b, want 0 1 1", busy, done, serial_out);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL left_done_pulse: got done=%b, want 0", done);
    end
  endtask

  task automatic test_right();
    logic [WIDTH-1:0] exp_final;
`ifdef SHIFT_REGISTER_UNIT_ARITH_EN
    exp_final = 8'hE0;
`else
    exp_final = 8'h20;
`endif
    do_load(8'h81);
    do_start(1'b1, 2, 1'b0);
    dir = 1'b0;
    tick(); tick();
    checks++;
    if (data_out !== exp_final || serial_out !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL right_final: got data=%h sout=%b done=%b busy=%b, want %h 0 1 0", data_out, serial_out, done, busy, exp_final);
    end
    tick();
  endtask

  task automatic test_zero();
    do_load(8'h3C);
    do_start(1'b0, 0, 1'b1);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || data_out !== 8'h3C) begin
      errors++;
      $display("FAIL zero_done: got done=%b busy=%b data=%h, want 1 0 3c", done, busy, data_out);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || data_out !== 8'h3C) begin
      errors++;
      $display("FAIL zero_after: got done=%b busy=%b data=%h, want 0 0 3c", done, busy, data_out);
    end
  endtask

  task automatic test_abort_ignore();
    do_load(8'hFF);
    do_start(1'b0, 6, 1'b0);
    load = 1'b1;
    data_in = 8'h11;
    tick();
    load = 1'b0;
    checks++;
    if (data_out !== 8'hFE || busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_load: got data=%h busy=%b, want fe 1", data_out, busy);
    end
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (data_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || serial_out !== 1'b0) begin
      errors++;
      $display("FAIL abort_clr: got data=%h busy=%b done=%b sout=%b, want 00 0 0 0", data_out, busy, done, serial_out);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_done: cycle %0d got busy=%b done=%b, want 0 0", i, busy, done);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_load(8'h01);
    do_start(1'b0, 2, 1'b0);
    tick(); tick();
    checks++;
    if (done !== 1'b1 || data_out !== 8'h04) begin
      errors++;
      $display("FAIL b2b_first_done: got done=%b data=%h, want 1 04", done, data_out);
    end
    do_start(1'b0, 1, 1'b0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b done=%b, want 1 0", busy, done);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || data_out !== 8'h08) begin
      errors++;
      $display("FAIL b2b_second_done: got busy=%b done=%b data=%h, want 0 1 08", busy, done, data_out);
    end
    tick();
  endtask

  // Model: the register is a window onto a growing bit stream built with plain shifts/ORs.
  task automatic test_random();
    logic [WIDTH-1:0] val, exp_data;
    logic             d, s, fill, exp_sout;
    longint           ext;
    int               n;
    for (int it = 0; it < 40; it++) begin
      val = WIDTH'($urandom);
      d = 1'($urandom);
      n = $urandom_range(0, 15);
      do_load(val);
      do_start(d, n, 1'b0);
      if (n == 0) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || data_out !== val) begin
          errors++;
          $display("FAIL rand_zero: it %0d got done=%b busy=%b data=%h, want 1 0 %h", it, done, busy, data_out, val);
        end
        tick();
        continue;
      end
      ext = d ? (longint'(val) << 16) : longint'(val);
      for (int i = 0; i < n; i++) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL rand_busy: it %0d step %0d got busy=%b done=%b, want 1 0", it, i, busy, done);
        end
        s = 1'($urandom);
        serial_in = s;
        dir = 1'($urandom);
        load = 1'($urandom);
        data_in = WIDTH'($urandom);
        if (!d) begin
          ext = (ext << 1) | longint'(s);
        end else begin
`ifdef SHIFT_REGISTER_UNIT_ARITH_EN
          fill = 1'((ext >> 23) & 1);
`else
          fill = s;
`endif
          ext = (ext >> 1) | (longint'(fill) << 23);
        end
        tick();
      end
      load = 1'b0;
      if (!d) begin
        exp_data = WIDTH'(ext & 64'hFF);
        exp_sout = 1'((ext >> 8) & 1);
      end else begin
        exp_data = WIDTH'((ext >> 16) & 64'hFF);
        exp_sout = 1'((ext >> 15) & 1);
      end
      checks++;
      if (data_out !== exp_data || serial_out !== exp_sout || busy !== 1'b0 || done !== 1'b1) begin
        errors++;
        $display("FAIL rand_result: it %0d dir=%b n=%0d got data=%h sout=%b busy=%b done=%b, want %h %b 0 1",
                 it, d, n, data_out, serial_out, busy, done, exp_data, exp_sout);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_left();
    test_right();
    test_zero();
    test_abort_ignore();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
